// File: rtl/pc_sequencer.sv
// Next-PC controller: owns PC, picks seq/jump/jr/branch, drives IF/ID flush; PC_DELAY_SLOT_EN ties Flush low.
// Latency: a redirect seen at edge N with Stall=0 is the PC after edge N (zero bubble).
// Backpressure: Stall freezes PC; a redirect seen while stalled is held (Pending) until release.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        IsBranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        IsJr,
    input  logic [31:0] RegTarget,
    input  logic        IsJump,
    input  logic [25:0] JumpField,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [1:0]  PCSel,
    output logic        Flush,
    output logic        Pending
);

    typedef enum logic {RUN, PEND} state_t;

    state_t      state;
    logic [31:0] lat_tgt;
    logic [1:0]  lat_cls;

    logic [1:0]  live_cls;
    logic [31:0] live_tgt;
    logic [31:0] jump_tgt;
    logic        apply;
    logic [1:0]  app_cls;
    logic [31:0] app_tgt;

    assign PCPlus4  = PC + 32'd4;
    assign jump_tgt = {PCPlus4[31:28], JumpField, 2'b00};

    // Branch resolves in EX for an older instruction, so it outranks ID-stage jr/j.
    always_comb begin
        live_cls = 2'd0;
        live_tgt = 32'd0;
        if (IsBranchTaken) begin
            live_cls = 2'd3;
            live_tgt = BranchTarget;
        end else if (IsJr) begin
            live_cls = 2'd2;
            live_tgt = RegTarget;
        end else if (IsJump) begin
            live_cls = 2'd1;
            live_tgt = jump_tgt;
        end
    end

    always_comb begin
        apply   = 1'b0;
        app_cls = live_cls;
        app_tgt = live_tgt;
        if (!Rst && !Stall) begin
            if (state == PEND) begin
                apply = 1'b1;
                // latched redirect wins ties against a live one of the same class
                if (lat_cls >= live_cls) begin
                    app_cls = lat_cls;
                    app_tgt = lat_tgt;
                end
            end else begin
                apply = (live_cls != 2'd0);
            end
        end
    end

    assign PCSel = apply ? app_cls : 2'd0;

`ifdef PC_DELAY_SLOT_EN
    assign Flush = 1'b0;
`else
    assign Flush = apply;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            PC      <= RESET_PC;
            state   <= RUN;
            Pending <= 1'b0;
            lat_tgt <= 32'd0;
            lat_cls <= 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (Stall) begin
                        if (live_cls != 2'd0) begin
                            lat_cls <= live_cls;
                            lat_tgt <= live_tgt;
                            state   <= PEND;
                            Pending <= 1'b1;
                        end
                    end else begin
                        PC <= apply ? app_tgt : PCPlus4;
                    end
                end
                PEND: begin
                    if (Stall) begin
                        if (live_cls > lat_cls) begin
                            lat_cls <= live_cls;
                            lat_tgt <= live_tgt;
                        end
                    end else begin
                        PC      <= app_tgt;
                        state   <= RUN;
                        Pending <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
